// File: rtl/clock_pkg.sv
// Shared types, field widths and time-field arithmetic for the 12-hour clock set controller.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_COMMIT  = 2'd3
    } state_e;

    localparam int unsigned HOUR_W   = 4;
    localparam int unsigned MIN_W    = 6;
    localparam int unsigned HOUR_MIN = 1;
    localparam int unsigned HOUR_MAX = 12;
    localparam int unsigned MIN_MAX  = 59;

    typedef struct packed {
        logic [HOUR_W-1:0] hours;
        logic [MIN_W-1:0]  minutes;
        logic              am_pm;
    } clk_time_t;

    // Out-of-range hours from the core are treated as 12.
    function automatic logic [HOUR_W-1:0] clamp_hour(input logic [HOUR_W-1:0] h);
        if (h == '0 || h > HOUR_W'(HOUR_MAX)) begin
            return HOUR_W'(HOUR_MAX);
        end
        return h;
    endfunction

    // 12 wraps to 1; stepping 11 -> 12 flips the meridiem.
    function automatic clk_time_t inc_hour(input clk_time_t t);
        clk_time_t r;
        r = t;
        if (t.hours >= HOUR_W'(HOUR_MAX)) begin
            r.hours = HOUR_W'(HOUR_MIN);
        end else begin
            r.hours = t.hours + HOUR_W'(1);
        end
        if (t.hours == HOUR_W'(HOUR_MAX - 1)) begin
            r.am_pm = ~t.am_pm;
        end
        return r;
    endfunction

    // Minutes wrap to 0 without carrying into hours.
    function automatic clk_time_t inc_minute(input clk_time_t t);
        clk_time_t r;
        r = t;
        if (t.minutes >= MIN_W'(MIN_MAX)) begin
            r.minutes = '0;
        end else begin
            r.minutes = t.minutes + MIN_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for an already synchronized, debounced button level.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise_c
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = btn;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise_c = btn & ~prev_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Seconds prescaler and two-button set-mode sequencer that edits a shadow copy
// of the clock core's time and loads it back with a one-cycle strobe.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic [HOUR_W-1:0] cur_hours,
    input  logic [MIN_W-1:0]  cur_minutes,
    input  logic              cur_am_pm,
    output logic              tick_en,
    output logic              load,
    output logic [HOUR_W-1:0] set_hours,
    output logic [MIN_W-1:0]  set_minutes,
    output logic              set_am_pm,
    output logic [1:0]        mode,
    output logic              blink
);

    localparam int unsigned PRESC_W = $clog2(TICK_DIV);
    localparam int unsigned TO_W    = $clog2(TIMEOUT_S + 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_HALF = PRESC_W'(TICK_DIV / 2);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_S - 1);

    state_e              state_q, state_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [TO_W-1:0]     to_q, to_d;
    clk_time_t           set_q, set_d;

    logic mode_evt_c;
    logic inc_evt_c;
    logic any_evt_c;
    logic presc_wrap_c;
    logic timeout_c;
    logic in_set_c;

    btn_edge u_mode_edge (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn_mode),
        .rise_c (mode_evt_c)
    );

    btn_edge u_inc_edge (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn_inc),
        .rise_c (inc_evt_c)
    );

    assign any_evt_c    = mode_evt_c | inc_evt_c;
    assign presc_wrap_c = (presc_q == PRESC_LAST);
    assign in_set_c     = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN);
    // Abort fires on the wrap that would bring the idle-seconds count to TIMEOUT_S.
    assign timeout_c    = in_set_c && presc_wrap_c && (to_q == TO_LAST) && !any_evt_c;

    // Next-state, prescaler, timeout and shadow-time update.
    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        presc_d = presc_wrap_c ? '0 : presc_q + PRESC_W'(1);
        to_d    = '0;

        if (in_set_c && !any_evt_c && presc_wrap_c) begin
            to_d = to_q + TO_W'(1);
        end else if (in_set_c && !any_evt_c) begin
            to_d = to_q;
        end

        case (state_q)
            ST_RUN: begin
                if (mode_evt_c) begin
                    set_d.hours   = clamp_hour(cur_hours);
                    set_d.minutes = cur_minutes;
                    set_d.am_pm   = cur_am_pm;
                    state_d       = ST_SET_HR;
                end
            end
            ST_SET_HR: begin
                if (mode_evt_c) begin
                    state_d = ST_SET_MIN;
                end else if (inc_evt_c) begin
                    set_d = inc_hour(set_q);
                end else if (timeout_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_SET_MIN: begin
                if (mode_evt_c) begin
                    state_d = ST_COMMIT;
                end else if (inc_evt_c) begin
                    set_d = inc_minute(set_q);
                end else if (timeout_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_COMMIT: begin
                state_d = ST_RUN;
                presc_d = '0;
                to_d    = '0;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        tick_en     = (state_q == ST_RUN) && presc_wrap_c;
        load        = (state_q == ST_COMMIT);
        blink       = in_set_c ? (presc_q < PRESC_HALF) : 1'b1;
        mode        = 2'(state_q);
        set_hours   = set_q.hours;
        set_minutes = set_q.minutes;
        set_am_pm   = set_q.am_pm;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            presc_q       <= '0;
            to_q          <= '0;
            set_q.hours   <= HOUR_W'(HOUR_MAX);
            set_q.minutes <= '0;
            set_q.am_pm   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            to_q    <= to_d;
            set_q   <= set_d;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Vector-table bench for clock_set_ctrl with TICK_DIV = 10 and TIMEOUT_S = 3.
module tb_clock_set_ctrl;

    localparam int unsigned TD = 10;
    localparam int unsigned TO = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] cur_hours = 4'd12;
    logic [5:0] cur_minutes = 6'd0;
    logic       cur_am_pm = 1'b0;
    logic       tick_en;
    logic       load;
    logic [3:0] set_hours;
    logic [5:0] set_minutes;
    logic       set_am_pm;
    logic [1:0] mode;
    logic       blink;

    clock_set_ctrl #(
        .TICK_DIV  (TD),
        .TIMEOUT_S (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .cur_hours   (cur_hours),
        .cur_minutes (cur_minutes),
        .cur_am_pm   (cur_am_pm),
        .tick_en     (tick_en),
        .load        (load),
        .set_hours   (set_hours),
        .set_minutes (set_minutes),
        .set_am_pm   (set_am_pm),
        .mode        (mode),
        .blink       (blink)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       load;
        logic [3:0] h;
        logic [5:0] m;
        logic       ap;
        logic [1:0] mode;
        logic       blink;
        logic       chk_set;
    } exp_t;

    typedef struct {
        logic rst_n;
        logic bm;
        logic bi;
        exp_t e;
    } vec_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    function automatic vec_t v(input logic r, input logic bm, input logic bi,
                               input logic tk, input logic ld, input int h, input int m,
                               input logic ap, input int md, input logic bl,
                               input logic cs = 1'b1);
        vec_t x;
        x.rst_n     = r;
        x.bm        = bm;
        x.bi        = bi;
        x.e.tick    = tk;
        x.e.load    = ld;
        x.e.h       = 4'(h);
        x.e.m       = 6'(m);
        x.e.ap      = ap;
        x.e.mode    = 2'(md);
        x.e.blink   = bl;
        x.e.chk_set = cs;
        return x;
    endfunction

    task automatic cmp(input string tag, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s: got %0d expected %0d", tag, fld, act, req);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t ex;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s.scoreboard: got empty queue expected one entry", tag);
        end else begin
            ex = sb_q.pop_front();
            cmp(tag, "tick_en", 32'(tick_en), 32'(ex.tick));
            cmp(tag, "load",    32'(load),    32'(ex.load));
            cmp(tag, "mode",    32'(mode),    32'(ex.mode));
            cmp(tag, "blink",   32'(blink),   32'(ex.blink));
            if (ex.chk_set) begin
                cmp(tag, "set_hours",   32'(set_hours),   32'(ex.h));
                cmp(tag, "set_minutes", 32'(set_minutes), 32'(ex.m));
                cmp(tag, "set_am_pm",   32'(set_am_pm),   32'(ex.ap));
            end
        end
    endtask

    // Row i is applied before clock edge i; row 0 is always a reset row.
    task automatic run_tbl(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst      = tbl[i].rst_n;
            btn_mode = tbl[i].bm;
            btn_inc  = tbl[i].bi;
            sb_q.push_back(tbl[i].e);
            @(posedge clk);
            #1;
            check_out($sformatf("%s[%0d]", name, i));
        end
        tbl.delete();
    endtask

    task automatic set_cur(input int h, input int m, input logic ap);
        cur_hours   = 4'(h);
        cur_minutes = 6'(m);
        cur_am_pm   = ap;
    endtask

    initial begin
        // Free-running ticks after reset.
        set_cur(7, 30, 1'b0);
        tbl.push_back(v(0, 0, 0, 0, 0, 12, 0, 0, 0, 1));
        for (int e = 1; e <= 35; e++) begin
            tbl.push_back(v(1, 0, 0, (e % 10) == 9, 0, 12, 0, 0, 0, 1));
        end
        run_tbl("run_ticks");

        // Hour edit across 11 -> 12 -> 1.
        set_cur(11, 59, 1'b0);
        tbl.push_back(v(0, 0, 0, 0, 0, 12, 0,  0, 0, 1));
        tbl.push_back(v(1, 1, 0, 0, 0, 11, 59, 0, 1, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 11, 59, 0, 1, 1));
        tbl.push_back(v(1, 0, 1, 0, 0, 12, 59, 1, 1, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 12, 59, 1, 1, 1));
        tbl.push_back(v(1, 0, 1, 0, 0, 1,  59, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 1,  59, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 1,  59, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 1,  59, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 1,  59, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 1,  59, 1, 1, 1));
        run_tbl("hour_edit");

        // Minute edit with wrap, commit, then tick realignment.
        set_cur(3, 58, 1'b0);
        tbl.push_back(v(0, 0, 0, 0, 0, 12, 0,  0, 0, 1));
        tbl.push_back(v(1, 1, 0, 0, 0, 3,  58, 0, 1, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 3,  58, 0, 1, 1));
        tbl.push_back(v(1, 1, 0, 0, 0, 3,  58, 0, 2, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 3,  58, 0, 2, 1));
        tbl.push_back(v(1, 0, 1, 0, 0, 3,  59, 0, 2, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 3,  59, 0, 2, 0));
        tbl.push_back(v(1, 0, 1, 0, 0, 3,  0,  0, 2, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 3,  0,  0, 2, 0));
        tbl.push_back(v(1, 0, 1, 0, 0, 3,  1,  0, 2, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 3,  1,  0, 2, 1));
        tbl.push_back(v(1, 1, 0, 0, 1, 3,  1,  0, 3, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 3,  1,  0, 0, 1));
        for (int k = 1; k <= 10; k++) begin
            tbl.push_back(v(1, 0, 0, k == 9, 0, 3, 1, 0, 0, 1));
        end
        run_tbl("min_commit");

        // Idle timeout in SET_HR: third seconds wrap aborts without load.
        set_cur(8, 15, 1'b1);
        tbl.push_back(v(0, 0, 0, 0, 0, 12, 0, 0, 0, 1));
        tbl.push_back(v(1, 1, 0, 0, 0, 8, 15, 1, 1, 1));
        for (int e = 2; e <= 29; e++) begin
            tbl.push_back(v(1, 0, 0, 0, 0, 8, 15, 1, 1, (e % 10) < 5));
        end
        tbl.push_back(v(1, 0, 0, 0, 0, 8, 15, 1, 0, 1, 1'b0));
        for (int e = 31; e <= 40; e++) begin
            tbl.push_back(v(1, 0, 0, (e % 10) == 9, 0, 8, 15, 1, 0, 1, 1'b0));
        end
        run_tbl("timeout");

        // Simultaneous events, held inc, then reset mid-edit.
        set_cur(5, 20, 1'b1);
        tbl.push_back(v(0, 0, 0, 0, 0, 12, 0,  0, 0, 1));
        tbl.push_back(v(1, 1, 0, 0, 0, 5,  20, 1, 1, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 5,  20, 1, 1, 1));
        tbl.push_back(v(1, 1, 1, 0, 0, 5,  20, 1, 2, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 5,  20, 1, 2, 1));
        for (int e = 5; e <= 24; e++) begin
            tbl.push_back(v(1, 0, 1, 0, 0, 5, 21, 1, 2, (e % 10) < 5));
        end
        tbl.push_back(v(1, 0, 0, 0, 0, 5,  21, 1, 2, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 12, 0,  0, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 12, 0,  0, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 12, 0,  0, 0, 1));
        run_tbl("simul_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-setting and sequencing controller for the 12-hour clock core. Generates the core's once-per-second advance enable and runs a two-button set-mode state machine (hours, then minutes) that edits a shadow copy of the current time. The edited time is loaded back into the core with a single-cycle load strobe. Sits between the debounced front-panel buttons and the clock core's enable/load inputs; also drives the display blink signal.

## Interface
- TICK_DIV, 100_000_000: clk cycles per second; ≥ 4.
- TIMEOUT_S, 30: seconds without a button edge in set mode before abort; ≥ 1.

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- btn_mode  in  1  mode button, level, already synchronized and debounced.
- btn_inc  in  1  increment button, level, already synchronized and debounced.
- cur_hours  in  4  core's current hours, 1..12.
- cur_minutes  in  6  core's current minutes, 0..59.
- cur_am_pm  in  1  core's current meridiem; 0 = AM, 1 = PM.
- tick_en  out  1  one-cycle pulse; advances the core by one second.
- load  out  1  one-cycle strobe; core loads set_* and clears seconds to 0.
- set_hours  out  4  edited hours, 1..12.
- set_minutes  out  6  edited minutes, 0..59.
- set_am_pm  out  1  edited meridiem.
- mode  out  2  current state encoding: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 COMMIT.
- blink  out  1  display blink for the field being edited.

## Operation
- Edge detect: an event is a cycle in which the button is 1 and its registered previous value is 0. Holding a button produces exactly one event.
- Prescaler `presc` counts 0..TICK_DIV-1 and wraps, in all states except COMMIT.
- RUN:
  - tick_en = 1 when presc == TICK_DIV-1.
  - A btn_mode event captures cur_* into set_* and moves to SET_HR.
  - Captured cur_hours of 0 or >12 is forced to 12.
  - btn_inc events are ignored.
- SET_HR:
  - tick_en is held 0; the core is paused.
  - A btn_inc event updates hours: 12 → 1; otherwise +1. Going 11 → 12 toggles set_am_pm.
  - A btn_mode event moves to SET_MIN.
- SET_MIN:
  - A btn_inc event updates minutes: 59 → 0, with no carry into hours.
  - A btn_mode event moves to COMMIT.
- COMMIT (exactly one cycle):
  - load = 1 with set_* stable.
  - presc and the timeout counter clear to 0.
  - Next state is RUN.
- Timeout:
  - In SET_HR/SET_MIN, a seconds counter increments at each presc wrap and clears on any button event.
  - When it reaches TIMEOUT_S, return to RUN with no load; edits are discarded and the core resumes from its paused value.
- Simultaneous mode and inc events: mode wins, inc is dropped.
- blink:
  - In SET_HR/SET_MIN: 1 while presc < TICK_DIV/2, else 0.
  - In RUN/COMMIT: 1.

## Timing
- Reset (rst = 0 at a clock edge):
  - State RUN, presc 0, timeout counter 0, edge registers 0.
  - Outputs: tick_en 0, load 0, set_hours 12, set_minutes 0, set_am_pm 0, mode 0, blink 1.
- Reset mid-set discards edits; no load is issued.
- State, presc and set_* are registered. tick_en, load and blink are decoded from registered state only; there is no combinational path from inputs.
- First tick_en occurs in the TICK_DIV-th cycle after reset release; after that, every TICK_DIV cycles while in RUN.
- A button event sampled at edge n is visible on mode/set_* after edge n.
- Load latency: a btn_mode event in SET_MIN at edge n gives load high in cycle n+1 only, and mode = 0 at edge n+2.
- After COMMIT, the next tick_en is TICK_DIV cycles after RUN re-entry.

## Structure
- Package clock_pkg:
  - state enum (RUN, SET_HR, SET_MIN, COMMIT);
  - HOUR_W = 4, MIN_W = 6;
  - HOUR_MIN = 1, HOUR_MAX = 12, MIN_MAX = 59.
- Sub-module btn_edge: registered rising-edge detector, instantiated twice (btn_mode, btn_inc). All other logic lives in clock_set_ctrl.

## Test plan
All scenarios use TICK_DIV = 10, TIMEOUT_S = 3.
- Reset then RUN for 35 cycles → tick_en pulses in cycles 10, 20 and 30 only; load stays 0; mode = 0.
- cur = 11:59 AM; mode press, then 2 inc presses → set_hours 11 → 12 (set_am_pm = 1) → 1 (set_am_pm stays 1); tick_en stays 0 throughout.
- cur = 3:58; mode, mode, 3 inc presses, mode → set_minutes 58 → 59 → 0 → 1, set_hours stays 3; load high for exactly 1 cycle with 3:01; tick_en next fires 10 cycles later.
- Enter SET_HR, then no buttons for 30 cycles → mode returns to 0; load never asserts; tick_en resumes.
- btn_mode and btn_inc rise in the same cycle while in SET_HR → mode goes to 2, set_hours unchanged; btn_inc held 20 cycles in SET_MIN → exactly one increment.
- rst = 0 while in SET_MIN with edited values → all outputs return to reset values next cycle; no load is issued.
